// File: rtl/blk_arb_rr.sv
// Round-robin block arbiter: pulls framed blocks (CW + LEN words) from NFIFO channel FIFOs onto a 16-bit GTP word stream with comma fill.
// Optional trigger-word injection is built only when BLK_ARB_TRIG_EN is defined.
module blk_arb_rr #(
  parameter int          NFIFO    = 17,
  parameter int          LENBITS  = 9,
  parameter int          GAP      = 2,
  parameter logic [15:0] COMMA    = 16'h50BC,
  parameter logic [15:0] TRIGWORD = 16'h1CBC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NFIFO-1:0]     fifo_have,
  output logic [NFIFO-1:0]     arb_want,
  input  logic [16*NFIFO-1:0]  datain,
  input  logic                 trig,
  output logic [15:0]          dataout,
  output logic                 kchar,
  output logic                 err_ovr,
  output logic                 err_undr
);

  localparam int SELW = (NFIFO > 1) ? $clog2(NFIFO) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_WAITCW, S_BODY, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic [SELW-1:0]      last_q, last_d;
  logic [LENBITS-1:0]   rem_q, rem_d;
  logic [15:0]          cw_q, cw_d;
  logic                 cw_out_q, cw_out_d;
  logic                 vld_q, vld_d;
  logic [3:0]           gap_q, gap_d;
  logic [NFIFO-1:0]     arb_want_q, arb_want_d;
  logic [15:0]          dataout_q, dataout_d;
  logic                 kchar_q, kchar_d;
  logic                 err_ovr_q, err_ovr_d;
  logic                 err_undr_q, err_undr_d;

  logic [15:0]          word;
  logic [15:0]          fill_w;
  logic [SELW-1:0]      winner;
  logic                 found;
  int                   cand;

  assign word = datain[16*sel_q +: 16];

`ifdef BLK_ARB_TRIG_EN
  logic trig_q, pend_q, pend_d;

  // A trigger raised during a block waits for the next IDLE/GAP fill slot.
  always_comb begin
    pend_d = (pend_q & ~(state_q == S_IDLE || state_q == S_GAP)) | (trig & ~trig_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      trig_q <= trig;
      pend_q <= pend_d;
    end
  end

  assign fill_w = pend_q ? TRIGWORD : COMMA;
`else
  logic unused_trig;
  assign unused_trig = trig ^ (^TRIGWORD);
  assign fill_w      = COMMA;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= NFIFO; i++) begin
      cand = (int'(last_q) + i >= NFIFO) ? int'(last_q) + i - NFIFO : int'(last_q) + i;
      if (!found && fifo_have[SELW'(cand)]) begin
        found  = 1'b1;
        winner = SELW'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    rem_d      = rem_q;
    cw_d       = cw_q;
    cw_out_d   = 1'b0;
    vld_d      = |arb_want_q;
    gap_d      = gap_q;
    arb_want_d = '0;
    dataout_d  = COMMA;
    kchar_d    = 1'b1;
    err_ovr_d  = 1'b0;
    err_undr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        dataout_d = fill_w;
        if (found) begin
          sel_d      = winner;
          last_d     = winner;
          arb_want_d = {{(NFIFO-1){1'b0}}, 1'b1} << winner;
          state_d    = S_HEAD;
        end
      end

      S_HEAD: state_d = S_WAITCW;

      S_WAITCW: begin
        if (!word[15]) begin
          err_ovr_d = 1'b1;
          gap_d     = '0;
          state_d   = S_GAP;
        end else begin
          // The CW is held one cycle so the body words follow it without a bubble.
          cw_d     = word;
          cw_out_d = 1'b1;
          state_d  = S_BODY;
          if (word[LENBITS-1:0] != '0) begin
            arb_want_d = {{(NFIFO-1){1'b0}}, 1'b1} << sel_q;
            rem_d      = word[LENBITS-1:0] - LENBITS'(1);
          end else begin
            rem_d = '0;
          end
        end
      end

      S_BODY: begin
        if (cw_out_q) begin
          dataout_d = cw_q;
          kchar_d   = 1'b0;
        end else if (vld_q) begin
          if (word[15]) begin
            err_undr_d = 1'b1;
            gap_d      = '0;
            state_d    = S_GAP;
          end else begin
            dataout_d = word;
            kchar_d   = 1'b0;
          end
        end
        if (state_d == S_BODY) begin
          if (rem_q != '0) begin
            arb_want_d = {{(NFIFO-1){1'b0}}, 1'b1} << sel_q;
            rem_d      = rem_q - LENBITS'(1);
          end else if (arb_want_q == '0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        dataout_d = fill_w;
        if (gap_q == 4'(GAP - 1)) state_d = S_IDLE;
        else                      gap_d   = gap_q + 4'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      last_q     <= SELW'(NFIFO - 1);
      rem_q      <= '0;
      cw_q       <= '0;
      cw_out_q   <= 1'b0;
      vld_q      <= 1'b0;
      gap_q      <= '0;
      arb_want_q <= '0;
      dataout_q  <= COMMA;
      kchar_q    <= 1'b1;
      err_ovr_q  <= 1'b0;
      err_undr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge value of the others.
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      rem_q      <= rem_d;
      cw_q       <= cw_d;
      cw_out_q   <= cw_out_d;
      vld_q      <= vld_d;
      gap_q      <= gap_d;
      arb_want_q <= arb_want_d;
      dataout_q  <= dataout_d;
      kchar_q    <= kchar_d;
      err_ovr_q  <= err_ovr_d;
      err_undr_q <= err_undr_d;
    end
  end

  assign arb_want = arb_want_q;
  assign dataout  = dataout_q;
  assign kchar    = kchar_q;
  assign err_ovr  = err_ovr_q;
  assign err_undr = err_undr_q;

endmodule

// File: tb/tb_blk_arb_rr.sv
// Scoreboard bench for blk_arb_rr (NFIFO=4): directed blocks are queued with their expected link words,
// and a monitor pops and compares every non-idle word the DUT emits.
module tb_blk_arb_rr;
  localparam int          N       = 4;
  localparam int          GAPV    = 2;
  localparam logic [15:0] COMMA_W = 16'h50BC;
  localparam logic [15:0] TRIG_W  = 16'h1CBC;
`ifdef BLK_ARB_TRIG_EN
  localparam int EXP_TRIG = 1;
`else
  localparam int EXP_TRIG = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            trig = 1'b0;
  logic [N-1:0]    fifo_have = '0;
  logic [N-1:0]    arb_want;
  logic [16*N-1:0] datain = '0;
  logic [15:0]     dataout;
  logic            kchar, err_ovr, err_undr;

  always #4 clk = ~clk;

  blk_arb_rr #(.NFIFO(N), .GAP(GAPV)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_have(fifo_have), .arb_want(arb_want),
    .datain(datain), .trig(trig), .dataout(dataout), .kchar(kchar),
    .err_ovr(err_ovr), .err_undr(err_undr)
  );

  typedef struct packed { logic k; logic [15:0] d; } word_t;

  word_t       sb[$];
  word_t       e;
  logic [15:0] fq [N][$];
  logic [15:0] nxt [N] = '{default: 16'h0000};

  int n_vec = 0, n_bad = 0;
  int want_cnt [N] = '{default: 0};
  int ovr_cnt = 0, undr_cnt = 0, trig_cnt = 0, data_cnt = 0, overlap_cnt = 0;
  int comma_run = 0, min_gap = 1000;
  bit seen_cw = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model: a read strobe seen in cycle t presents the popped word during cycle t+1.
  always begin
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (arb_want[k] && rst_n) begin
        if (fq[k].size() > 0) nxt[k] = fq[k].pop_front();
        else                  nxt[k] = 16'hFFFF;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      datain[16*k +: 16] = nxt[k];
      fifo_have[k]       = (fq[k].size() != 0);
    end
  end

  // Monitor: every word that is not a plain comma must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_cw   = 1'b0;
      comma_run = 0;
    end else begin
      for (int k = 0; k < N; k++) want_cnt[k] += int'(arb_want[k]);
      if ($countones(arb_want) > 1) overlap_cnt++;
      if (err_ovr)  ovr_cnt++;
      if (err_undr) undr_cnt++;
      if (kchar && dataout == TRIG_W) trig_cnt++;
      if (kchar) comma_run++;
      else begin
        data_cnt++;
        if (dataout[15]) begin
          if (seen_cw && comma_run < min_gap) min_gap = comma_run;
          seen_cw = 1'b1;
        end
        comma_run = 0;
      end
      if (!kchar || dataout != COMMA_W) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_word: got k=%0b d=%h expected idle comma", kchar, dataout);
        end else begin
          e = sb.pop_front();
          check("stream", {15'b0, kchar, dataout}, {15'b0, e});
        end
      end
    end
  end

  task automatic load_block(input int ch, input int len, input int tag);
    logic [15:0] w;
    w = 16'h8000 | 16'(len);
    fq[ch].push_back(w);
    sb.push_back({1'b0, w});
    for (int i = 0; i < len; i++) begin
      w = {1'b0, 7'(tag), 8'(i + 1)};
      fq[ch].push_back(w);
      sb.push_back({1'b0, w});
    end
  endtask

  function automatic bit fifos_busy();
    for (int k = 0; k < N; k++) if (fq[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((sb.size() != 0 || fifos_busy()) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    for (int k = 0; k < N; k++) fq[k].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arb_want"}, 32'(arb_want), 32'h0);
    check({tag, "_dataout"},  32'(dataout),  32'(COMMA_W));
    check({tag, "_kchar"},    32'(kchar),    32'h1);
    check({tag, "_err_ovr"},  32'(err_ovr),  32'h0);
    check({tag, "_err_undr"}, 32'(err_undr), 32'h0);
  endtask

  int w0, o0, u0, t0, d0, ov0, lim;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single block on fifo 2: CW, three data words, exactly four read strobes.
    w0 = want_cnt[2];
    load_block(2, 3, 1);
    wait_drain(300);
    check("single_want2_cycles", 32'(want_cnt[2] - w0), 32'd4);

    // All fifos loaded twice: grants 0,1,2,3,0,1,2,3 with LEN 2,0,1,3.
    do_reset();
    ov0 = overlap_cnt;
    for (int r = 0; r < 2; r++) begin
      load_block(0, 2, r * 4 + 1);
      load_block(1, 0, r * 4 + 2);
      load_block(2, 1, r * 4 + 3);
      load_block(3, 3, r * 4 + 4);
    end
    wait_drain(600);
    check("rr_no_overlap", 32'(overlap_cnt - ov0), 32'd0);

    // Fifo 1 returns a non-CW: one err_ovr, nothing emitted, fifo 2 served next.
    do_reset();
    o0 = ovr_cnt;
    load_block(0, 1, 9);
    fq[1].push_back(16'h0123);
    load_block(2, 2, 10);
    wait_drain(400);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);

    // CW 8005 whose 3rd data word carries bit15: stream stops after word 2.
    do_reset();
    u0 = undr_cnt;
    w0 = want_cnt[3];
    fq[3].push_back(16'h8005);
    sb.push_back({1'b0, 16'h8005});
    fq[3].push_back(16'h000A);
    sb.push_back({1'b0, 16'h000A});
    fq[3].push_back(16'h000B);
    sb.push_back({1'b0, 16'h000B});
    fq[3].push_back(16'h8001);
    fq[3].push_back(16'h000C);
    wait_drain(300);
    check("undr_pulses", 32'(undr_cnt - u0), 32'd1);
    check("undr_want3_cycles", 32'(want_cnt[3] - w0), 32'd5);

    // Two trig pulses during a 10-word block merge into at most one TRIGWORD.
    do_reset();
    t0 = trig_cnt;
    d0 = data_cnt;
    load_block(1, 10, 11);
    if (EXP_TRIG != 0) sb.push_back({1'b1, TRIG_W});
    lim = 0;
    while (data_cnt < d0 + 3 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    @(negedge clk);
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    wait_drain(300);
    check("trig_words", 32'(trig_cnt - t0), 32'(EXP_TRIG));

    // Reset mid-body: outputs clear at once, then channel 0 wins first again.
    do_reset();
    d0 = data_cnt;
    load_block(2, 10, 12);
    lim = 0;
    while (data_cnt < d0 + 4 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int k = 0; k < N; k++) fq[k].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_block(0, 1, 13);
    load_block(1, 2, 14);
    load_block(3, 1, 15);
    wait_drain(400);

    check("min_comma_gap_ok", 32'(min_gap >= GAPV), 32'd1);
    check("total_no_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/blk_arb_rr.md
# blk_arb_rr

Parametrised round-robin block arbiter feeding the GTP transmit lane. It collects framed data blocks from NFIFO channel FIFOs and serialises them onto a 16-bit word stream with comma fill between blocks. It checks block framing and reports overrun/underrun. It succeeds the fixed-format sender arbiter, adding a configurable channel count, block-length field width and minimum inter-block gap, plus optional trigger-word injection.

## Interface
- NFIFO, 17, number of channel FIFOs (2..32)
- LENBITS, 9, width of the length field in a block control word (CW)
- GAP, 2, minimum comma words between consecutive blocks (1..15)
- COMMA, 16'h50BC, idle word (sent with kchar=1)
- TRIGWORD, 16'h1CBC, trigger word (sent with kchar=1, only with BLK_ARB_TRIG_EN)
- clk  in  1  system clock (125 MHz GTP clock)
- rst_n  in  1  asynchronous active-low reset
- fifo_have  in  NFIFO  fifo k holds at least one complete block
- arb_want  out  NFIFO  read strobe to fifo k, one word per cycle
- datain  in  16*NFIFO  fifo output words; slice k is bits [16k+15:16k]
- trig  in  1  trigger pulse to be announced on the link
- dataout  out  16  word to GTP
- kchar  out  1  dataout is a K-character
- err_ovr  out  1  one-cycle pulse: no CW where one was expected
- err_undr  out  1  one-cycle pulse: CW arrived before the block length was exhausted

## Operation
- Block format: CW first, with bit15=1 and LEN=[LENBITS-1:0]. CW is followed by LEN data words, each with bit15=0. LEN=0 is legal (CW only).
- The FIFO read latency is fixed: arb_want[k] asserted in cycle t means datain slice k is valid in cycle t+1.
- States:
  - IDLE: send COMMA. If a trigger is pending, send TRIGWORD instead. If any fifo_have bit is set, grant and go to HEAD.
  - HEAD: assert arb_want[sel] for one cycle, then go to WAITCW.
  - WAITCW: examine the word.
    - bit15=0: pulse err_ovr, send nothing from the word (COMMA output), go to GAP.
    - bit15=1: output the word with kchar=0 and load remaining=LEN. If LEN=0, go to GAP; else go to BODY.
  - BODY: assert arb_want[sel] for LEN consecutive cycles and output each returned word with kchar=0.
    - A returned word with bit15=1 pulses err_undr. That word and all subsequent reads of the block are suppressed: no further arb_want, and output reverts to COMMA. Words already requested are discarded. Go to GAP.
  - GAP: send COMMA (or a pending TRIGWORD) for GAP cycles, then go to IDLE.
- Grant rule: search fifo_have starting at index last+1, wrapping modulo NFIFO. The first set bit wins, and last is updated to the winner. Reset sets last=NFIFO-1, so channel 0 has first priority.
- fifo_have is sampled only in IDLE. Changes in fifo_have during a block are ignored.
- Only arb_want[sel] can be asserted at any time; all other bits stay 0.
- remaining is LENBITS wide and decrements once per issued arb_want in BODY.

## Timing
- Reset (asynchronous, rst_n=0) drives:
  - arb_want=0, err_ovr=0, err_undr=0
  - dataout=COMMA, kchar=1
  - state=IDLE, last=NFIFO-1, trigger pending flag cleared
- All outputs are registered.
- CW appears on dataout 2 cycles after the HEAD-cycle arb_want. Data words follow back-to-back with no bubbles.
- Per-block link occupancy is LEN+1 words plus at least GAP commas plus 1 arbitration cycle.
- Deasserting rst_n mid-block abandons the block. The FIFO side is re-synchronised by its own reset.
- trig arriving in IDLE/GAP in the same cycle as a grant is held pending and sent in the next GAP.

## Configuration
- BLK_ARB_TRIG_EN defined:
  - A rising trig sets a pending flag, and additional pulses while the flag is set merge into it.
  - The flag is cleared when TRIGWORD is sent in place of one COMMA in IDLE or GAP. That substitution counts as a gap cycle.
  - Worst-case trigger latency is the current block length plus GAP+3 cycles.
- BLK_ARB_TRIG_EN undefined: trig is ignored, and TRIGWORD and the pending flag are not synthesised.

## Test plan
- NFIFO=4, only fifo 2 has a block CW=16'h8003 plus 3 words → dataout 8003,d0,d1,d2 with kchar=0, then 2 COMMAs; exactly 4 arb_want[2] cycles.
- All 4 FIFOs hold blocks continuously → grants cycle in the order 0,1,2,3,0; no gap shorter than GAP; no arb_want overlap.
- Fifo 1 returns 16'h0123 for the CW → err_ovr pulses once, no data words are emitted, and the next grant goes to fifo 2.
- CW 16'h8005 with the 3rd data word equal to 16'h8001 → err_undr pulses once, output reverts to COMMA after word 2, and arb_want stops.
- With BLK_ARB_TRIG_EN, trig pulses twice during a 10-word block → exactly one TRIGWORD (kchar=1) appears in the following gap. With the macro undefined, no TRIGWORD ever appears.
- rst_n asserted mid-BODY → all outputs return to their reset values immediately; after release, channel 0 is granted first.
